// File: rtl/countdown_timer.sv
// countdown_timer
//   Three-digit BCD time register (M:SS) for the microwave datapath.
//   While stopped (en=0) each key press shifts a digit in from the right;
//   while cooking (en=1) each rising edge of pgt_1Hz decrements the time
//   with a BCD borrow chain, holding at 0:00.
//
// Ports
//   clock     in   system clock, all registers on rising edge
//   reset     in   synchronous active-high reset
//   BCD       in   [3:0] key digit, valid while loadn=0
//   loadn     in   active-low load strobe, low for the whole key press
//   pgt_1Hz   in   1 Hz square wave
//   en        in   1 = counting, 0 = key entry allowed
//   sec_ones  out  [3:0] seconds units digit
//   sec_tens  out  [3:0] seconds tens digit
//   mins      out  [3:0] minutes digit
//   done      out  one-cycle pulse when the countdown reaches 0:00
//                  (present only when TIMER_DONE_PULSE_EN is defined)
//   zero      out  1 when all three digits are 0
//
// Build option: define TIMER_DONE_PULSE_EN to add the done port/register.

module countdown_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] BCD,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       en,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
`ifdef TIMER_DONE_PULSE_EN
  output logic       done,
`endif
  output logic       zero
);

  logic loadn_d;
  logic tick_d;
  logic load_ev;
  logic tick_ev;
  logic do_load;
  logic do_dec;

  // Reset values (loadn_d=0, tick_d=1) suppress events from inputs that are
  // already active when reset is released.
  assign load_ev = loadn_d & ~loadn;
  assign tick_ev = ~tick_d & pgt_1Hz;
  assign zero    = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (mins == 4'd0);
  assign do_load = load_ev & ~en & (BCD <= 4'd9);
  assign do_dec  = tick_ev & en & ~zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      sec_ones <= '0;
      sec_tens <= '0;
      mins     <= '0;
      loadn_d  <= 1'b0;
      tick_d   <= 1'b1;
    end else begin
      loadn_d <= loadn;
      tick_d  <= pgt_1Hz;
      if (do_load) begin
        mins     <= sec_tens;
        sec_tens <= sec_ones;
        sec_ones <= BCD;
      end else if (do_dec) begin
        if (sec_ones == 4'd0) begin
          sec_ones <= 4'd9;
          if (sec_tens == 4'd0) begin
            sec_tens <= 4'd5;
            mins     <= mins - 4'd1;
          end else begin
            sec_tens <= sec_tens - 4'd1;
          end
        end else begin
          sec_ones <= sec_ones - 4'd1;
        end
      end
    end
  end

`ifdef TIMER_DONE_PULSE_EN
  // Only a decrement from 0:01 lands on 0:00; key entry of 0:00 does not pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= do_dec && (mins == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
    end
  end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] BCD;
  logic       loadn;
  logic       pgt_1Hz;
  logic       en;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] mins;
  logic       zero;
`ifdef TIMER_DONE_PULSE_EN
  logic       done;
`endif

  int total = 0;
  int bad   = 0;

  countdown_timer dut (
    .clock    (clock),
    .reset    (reset),
    .BCD      (BCD),
    .loadn    (loadn),
    .pgt_1Hz  (pgt_1Hz),
    .en       (en),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .mins     (mins),
`ifdef TIMER_DONE_PULSE_EN
    .done     (done),
`endif
    .zero     (zero)
  );

  always #5 clock = ~clock;

  // Model: the displayed time as a decimal number M*100 + T*10 + O.
  int unsigned m_val     = 0;
  bit          m_prev_ld = 1'b0;
  bit          m_prev_tk = 1'b1;
  bit          m_done    = 1'b0;
  bit          m_started = 1'b0;

  // Count down one second: plain -1 unless the seconds read 00, in which case
  // M:00 becomes (M-1):59, i.e. subtract 41.
  function automatic int unsigned dec_time(input int unsigned v);
    if ((v % 100) == 0) return v - 41;
    return v - 1;
  endfunction

  always @(posedge clock) begin
    bit ld, tk;
    if (reset) begin
      m_val     = 0;
      m_prev_ld = 1'b0;
      m_prev_tk = 1'b1;
      m_done    = 1'b0;
      m_started = 1'b1;
    end else begin
      ld = m_prev_ld && !loadn;
      tk = !m_prev_tk && pgt_1Hz;
      m_done = 1'b0;
      if (ld && !en) begin
        if (BCD <= 4'd9) m_val = (m_val * 10 + BCD) % 1000;
      end else if (tk && en && m_val != 0) begin
        m_val = dec_time(m_val);
        if (m_val == 0) m_done = 1'b1;
      end
      m_prev_ld = loadn;
      m_prev_tk = pgt_1Hz;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  int done_cnt = 0;
  always @(negedge clock) begin
    if (m_started) begin
      int unsigned got;
      got = mins * 100 + sec_tens * 10 + sec_ones;
      total++;
      if (got != m_val || zero != (m_val == 0)) begin
        bad++;
        $display("FAIL cycle t=%0t: got %0d:%0d%0d zero=%0b, want %0d zero=%0b",
                 $time, mins, sec_tens, sec_ones, zero, m_val, (m_val == 0));
      end
`ifdef TIMER_DONE_PULSE_EN
      total++;
      if (done !== m_done) begin
        bad++;
        $display("FAIL done t=%0t: got %0b want %0b", $time, done, m_done);
      end
      if (done) done_cnt++;
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Literal expectation for the display, sampled mid-cycle.
  task automatic chk(input string name, input int m, input int t, input int o, input bit z);
    @(negedge clock);
    total++;
    if (mins != m[3:0] || sec_tens != t[3:0] || sec_ones != o[3:0] || zero != z) begin
      bad++;
      $display("FAIL %s: got %0d:%0d%0d zero=%0b, want %0d:%0d%0d zero=%0b",
               name, mins, sec_tens, sec_ones, zero, m, t, o, z);
    end
  endtask

  task automatic press(input logic [3:0] d);
    BCD = d; loadn = 1'b0; cyc(3);
    loadn = 1'b1; cyc(2);
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1; cyc(2);
    pgt_1Hz = 1'b0; cyc(2);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2);
    reset = 1'b0; cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; BCD = '0; loadn = 1'b1; pgt_1Hz = 1'b0; en = 1'b0;
    cyc(2);
    reset = 1'b0; cyc(1);
    chk("reset", 0, 0, 0, 1'b1);

    press(4'd1); chk("entry1", 0, 0, 1, 1'b0);
    press(4'd3); chk("entry2", 0, 1, 3, 1'b0);
    press(4'd0); chk("entry3", 1, 3, 0, 1'b0);

    do_reset();
    BCD = 4'd7; loadn = 1'b0; cyc(50);
    loadn = 1'b1; cyc(2);
    chk("held_key", 0, 0, 7, 1'b0);

    do_reset();
    press(4'd1); press(4'd0); press(4'd0);
    chk("load_100", 1, 0, 0, 1'b0);
    en = 1'b1;
    tick(); chk("dec_059", 0, 5, 9, 1'b0);
    tick(); chk("dec_058", 0, 5, 8, 1'b0);
    tick(); chk("dec_057", 0, 5, 7, 1'b0);

    en = 1'b0; do_reset();
    press(4'd9); press(4'd9);
    chk("load_099", 0, 9, 9, 1'b0);
    done_cnt = 0;
    en = 1'b1;
    tick(); chk("dec_098", 0, 9, 8, 1'b0);
    repeat (98) tick();
    chk("reach_000", 0, 0, 0, 1'b1);
    repeat (3) tick();
    chk("hold_000", 0, 0, 0, 1'b1);
`ifdef TIMER_DONE_PULSE_EN
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL done_count: got %0d want 1", done_cnt);
    end
`endif

    en = 1'b0; do_reset();
    press(4'd4); chk("pre_lock", 0, 0, 4, 1'b0);
    en = 1'b1; cyc(1);
    press(4'd5); chk("load_while_en", 0, 0, 4, 1'b0);
    en = 1'b0; cyc(1);
    repeat (10) tick();
    chk("tick_while_stopped", 0, 0, 4, 1'b0);
    press(4'd12); chk("bcd_12_ignored", 0, 0, 4, 1'b0);

    do_reset();
    press(4'd2); press(4'd4); press(4'd5);
    chk("load_245", 2, 4, 5, 1'b0);
    en = 1'b1; pgt_1Hz = 1'b1; reset = 1'b1; cyc(1);
    chk("reset_mid", 0, 0, 0, 1'b1);
`ifdef TIMER_DONE_PULSE_EN
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %0b want 0", done);
    end
`endif
    reset = 1'b0; cyc(3);
    chk("tick_high_at_release", 0, 0, 0, 1'b1);
    pgt_1Hz = 1'b0;

    en = 1'b0; BCD = 4'd6; loadn = 1'b0; reset = 1'b1; cyc(2);
    reset = 1'b0; cyc(4);
    chk("key_low_at_release", 0, 0, 0, 1'b1);
    loadn = 1'b1; cyc(2);
    press(4'd8); chk("after_release", 0, 0, 8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Three-digit BCD time register and countdown for the microwave datapath, directly downstream of `control_input`. It consumes `BCD`, `loadn` and `pgt_1Hz`. Key digits shift in from the right while the oven is stopped, and the register counts down once per 1 Hz tick while running. The digit outputs drive the display decoders, and `zero` goes to the top-level control FSM.

## Interface
Parameters: none.
- `clock`  in  1  system clock; every register updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `BCD`  in  4  digit from `control_input`, valid while `loadn` = 0
- `loadn`  in  1  active-low load strobe from `control_input`; held low for as long as a key is pressed
- `pgt_1Hz`  in  1  1 Hz square wave from `control_input`
- `en`  in  1  count enable from control: 1 = cooking (count), 0 = stopped (entry allowed)
- `sec_ones`  out  4  seconds units digit, BCD
- `sec_tens`  out  4  seconds tens digit, BCD
- `mins`  out  4  minutes digit, BCD
- `zero`  out  1  1 when all three digits are 0 (combinational from digit registers)
- `done`  out  1  only with `TIMER_DONE_PULSE_EN`; one-cycle pulse when countdown reaches 0:00

## Operation
- Edge detectors:
  - `loadn_d` holds the previous-cycle sample of `loadn`; load event = `loadn_d`=1 and `loadn`=0.
  - `tick_d` holds the previous-cycle sample of `pgt_1Hz`; tick event = `tick_d`=0 and `pgt_1Hz`=1.
- One load event per key press, however long `loadn` is held.
- Load (event and `en`=0):
  - If `BCD` ≤ 9: `mins`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`BCD`.
  - If `BCD` > 9: ignored, digits unchanged.
- Decrement (tick event, `en`=1, `zero`=0), BCD borrow chain:
  - `sec_ones` 0→9 and borrow from `sec_tens`, else `sec_ones`−1.
  - `sec_tens` 0→5 and borrow from `mins`, else `sec_tens`−1.
  - `mins` − 1.
- Seconds tens above 5 come only from key entry (e.g. 0:99) and count down normally until they reach 0, then borrow as above.
- At 0:00 with `en`=1: ticks are ignored and the register holds at 0:00; no wrap to 9:59.
- Priority: `reset` > load (only when `en`=0) > decrement (only when `en`=1).
  - A load event while `en`=1 is discarded.
  - A tick event while `en`=0 is discarded.
  - The two can never act in the same cycle.
- Edge detector registers track their inputs every cycle regardless of `en`. A key held across an `en` 1→0 change therefore does not produce a late load.

## Timing
- Reset values: `sec_ones`=`sec_tens`=`mins`=0, `zero`=1, `done`=0, `loadn_d`=0, `tick_d`=1.
  - A `loadn` already low, or a `pgt_1Hz` already high, at reset release produces no event.
- Load latency: the digits show the new value immediately after the first rising edge at which `loadn`=0 is sampled, given `loadn`=1 was sampled on the edge before.
- Decrement latency: same as load, using `pgt_1Hz`.
- `zero` follows the digit registers in the same cycle (no added delay).
- `done`: registered, high for exactly the one cycle after the edge that moved the count from 0:01 to 0:00. It is not asserted after reset, or when 0:00 is reached by key entry.
- `reset` asserted mid-count: the next edge clears everything; any pending event is lost.

## Configuration
- `TIMER_DONE_PULSE_EN` defined: the `done` port and its register exist, behaving as described under Timing.
- Not defined: no `done` port and no register. All other behaviour is identical.

## Test plan
- Reset then entry, `en`=0: key pulses 1, 3, 0 → digits after each press 0:01, 0:13, 1:30; `zero` goes 1→0 on the first press.
- Held key: `loadn` low for 50 cycles with `BCD`=7 from 0:00 → exactly one shift, result 0:07.
- Countdown from 1:00, `en`=1: the next three ticks give 0:59, 0:58, 0:57.
- 0:99 countdown: first tick gives 0:98; after 99 ticks the count is 0:00 with `zero`=1. Further ticks hold 0:00. With the macro defined, `done` is high for exactly 1 cycle.
- Interlocks:
  - `en`=1 with a key press (`BCD`=5) → digits unchanged.
  - `en`=0 with 10 ticks → digits unchanged.
  - `BCD`=12 load with `en`=0 → ignored.
- `reset` pulsed at 2:45 during counting → the next edge gives 0:00, `zero`=1, `done`=0. A `pgt_1Hz` already high at release causes no decrement.
